// File: rtl/axi4_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// axi4_if : AXI4 bundle (AW/W/B/AR/R) with master and slave modports
// Rev 1.0
// ============================================================================
interface axi4_if #(
  parameter int N_BYTES    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 4
) (
  input logic ACLK,
  input logic ARESETn
);
  logic [ID_WIDTH-1:0]    AWID;
  logic [ADDR_WIDTH-1:0]  AWADDR;
  logic [7:0]             AWLEN;
  logic [2:0]             AWSIZE;
  logic [1:0]             AWBURST;
  logic                   AWVALID;
  logic                   AWREADY;
  logic [8*N_BYTES-1:0]   WDATA;
  logic [N_BYTES-1:0]     WSTRB;
  logic                   WLAST;
  logic                   WVALID;
  logic                   WREADY;
  logic [ID_WIDTH-1:0]    BID;
  logic [1:0]             BRESP;
  logic                   BUSER;
  logic                   BVALID;
  logic                   BREADY;
  logic [ID_WIDTH-1:0]    ARID;
  logic [ADDR_WIDTH-1:0]  ARADDR;
  logic [7:0]             ARLEN;
  logic [2:0]             ARSIZE;
  logic [1:0]             ARBURST;
  logic                   ARVALID;
  logic                   ARREADY;
  logic [ID_WIDTH-1:0]    RID;
  logic [8*N_BYTES-1:0]   RDATA;
  logic [1:0]             RRESP;
  logic                   RLAST;
  logic                   RVALID;
  logic                   RREADY;

  modport master (
    input  ACLK, ARESETn,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BUSER, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  ACLK, ARESETn,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BUSER, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
// axi4_rd_arbiter : two-master round-robin AXI4 read arbiter, one burst in flight
// Rev 1.0
// ============================================================================
module axi4_rd_arbiter #(
  parameter int N_BYTES    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 4
) (
  input  logic       ACLK,
  input  logic       ARESET,
  axi4_if.slave      s0,
  axi4_if.slave      s1,
  axi4_if.master     m,
  output logic [1:0] GRANT,
  output logic       BUSY,
  output logic       ERR
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

  state_e      state_q;
  logic [1:0]  grant_q;
  logic        busy_q;
  logic        err_q;
  logic        last_q;
  logic [7:0]  len_q;
  logic [8:0]  beat_q;

  logic                  sel;
  logic                  in_addr;
  logic                  in_data;
  logic                  win1;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  beat_at_len;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_valid;
  logic [8*N_BYTES-1:0]  r_data;
  logic                  unused_w;

  assign sel     = grant_q[1];
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  // On a tie the master that was not served last wins.
  assign win1    = s1.ARVALID & (~s0.ARVALID | ~last_q);

  always_comb begin
    if (sel) begin
      ar_id    = s1.ARID;
      ar_addr  = s1.ARADDR;
      ar_len   = s1.ARLEN;
      ar_size  = s1.ARSIZE;
      ar_burst = s1.ARBURST;
      ar_valid = s1.ARVALID;
    end else begin
      ar_id    = s0.ARID;
      ar_addr  = s0.ARADDR;
      ar_len   = s0.ARLEN;
      ar_size  = s0.ARSIZE;
      ar_burst = s0.ARBURST;
      ar_valid = s0.ARVALID;
    end
  end

  assign m.ARID     = ar_id;
  assign m.ARADDR   = ar_addr;
  assign m.ARLEN    = ar_len;
  assign m.ARSIZE   = ar_size;
  assign m.ARBURST  = ar_burst;
  assign m.ARVALID  = in_addr & ar_valid;
  assign s0.ARREADY = in_addr & grant_q[0] & m.ARREADY;
  assign s1.ARREADY = in_addr & grant_q[1] & m.ARREADY;

  assign r_data    = m.RDATA;
  assign s0.RID    = m.RID;
  assign s0.RDATA  = r_data;
  assign s0.RRESP  = m.RRESP;
  assign s0.RLAST  = m.RLAST;
  assign s1.RID    = m.RID;
  assign s1.RDATA  = r_data;
  assign s1.RRESP  = m.RRESP;
  assign s1.RLAST  = m.RLAST;
  assign s0.RVALID = in_data & grant_q[0] & m.RVALID;
  assign s1.RVALID = in_data & grant_q[1] & m.RVALID;
  assign m.RREADY  = in_data & (sel ? s1.RREADY : s0.RREADY);

  assign m.AWID     = '0;
  assign m.AWADDR   = '0;
  assign m.AWLEN    = '0;
  assign m.AWSIZE   = '0;
  assign m.AWBURST  = '0;
  assign m.AWVALID  = 1'b0;
  assign m.WDATA    = '0;
  assign m.WSTRB    = '0;
  assign m.WLAST    = 1'b0;
  assign m.WVALID   = 1'b0;
  assign m.BREADY   = 1'b0;
  assign s0.AWREADY = 1'b0;
  assign s0.WREADY  = 1'b0;
  assign s0.BVALID  = 1'b0;
  assign s0.BID     = '0;
  assign s0.BRESP   = '0;
  assign s0.BUSER   = 1'b0;
  assign s1.AWREADY = 1'b0;
  assign s1.WREADY  = 1'b0;
  assign s1.BVALID  = 1'b0;
  assign s1.BID     = '0;
  assign s1.BRESP   = '0;
  assign s1.BUSER   = 1'b0;

  assign unused_w = ^{s0.ACLK, s0.ARESETn, s0.AWID, s0.AWADDR, s0.AWLEN, s0.AWSIZE,
                      s0.AWBURST, s0.AWVALID, s0.WDATA, s0.WSTRB, s0.WLAST, s0.WVALID,
                      s0.BREADY, s1.ACLK, s1.ARESETn, s1.AWID, s1.AWADDR, s1.AWLEN,
                      s1.AWSIZE, s1.AWBURST, s1.AWVALID, s1.WDATA, s1.WSTRB, s1.WLAST,
                      s1.WVALID, s1.BREADY, m.ACLK, m.ARESETn, m.AWREADY, m.WREADY,
                      m.BID, m.BRESP, m.BUSER, m.BVALID};

  assign ar_hs       = m.ARVALID & m.ARREADY;
  assign r_hs        = m.RVALID & m.RREADY;
  assign beat_at_len = (beat_q == {1'b0, len_q});

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s0.ARVALID || s1.ARVALID) begin
            grant_q <= win1 ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            len_q   <= ar_len;
            beat_q  <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_q <= beat_q + 9'd1;
            // RLAST must coincide exactly with the beat numbered ARLEN.
            if (m.RLAST != beat_at_len) begin
              err_q <= 1'b1;
            end
            if (m.RLAST) begin
              state_q <= IDLE;
              grant_q <= 2'b00;
              busy_q  <= 1'b0;
              last_q  <= sel;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign GRANT = grant_q;
  assign BUSY  = busy_q;
  assign ERR   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axi4_rd_arbiter : directed self-checking bench for axi4_rd_arbiter
// Rev 1.0
// ============================================================================
module tb_axi4_rd_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rstn;
  logic [1:0] grant;
  logic       busy;
  logic       err;
  int         n_assert = 0;
  int         n_fail   = 0;

  assign rstn = ~rst;
  always #5 clk = ~clk;

  axi4_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) s0_if (.ACLK(clk), .ARESETn(rstn));
  axi4_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) s1_if (.ACLK(clk), .ARESETn(rstn));
  axi4_if #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) m_if  (.ACLK(clk), .ARESETn(rstn));

  axi4_rd_arbiter #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4)) dut (
    .ACLK  (clk),
    .ARESET(rst),
    .s0    (s0_if),
    .s1    (s1_if),
    .m     (m_if),
    .GRANT (grant),
    .BUSY  (busy),
    .ERR   (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  task automatic ar_req(input int idx, input logic [3:0] id, input logic [11:0] addr,
                        input logic [7:0] len);
    if (idx == 0) begin
      s0_if.ARVALID = 1'b1; s0_if.ARID = id; s0_if.ARADDR = addr; s0_if.ARLEN = len;
    end else begin
      s1_if.ARVALID = 1'b1; s1_if.ARID = id; s1_if.ARADDR = addr; s1_if.ARLEN = len;
    end
  endtask

  task automatic ar_drop(input int idx);
    if (idx == 0) s0_if.ARVALID = 1'b0;
    else          s1_if.ARVALID = 1'b0;
  endtask

  // Drives n R beats, RLAST on beat index last_at, each accepted in one cycle.
  task automatic run_beats(input int idx, input int n, input int last_at,
                           input logic [3:0] id, input string tag);
    for (int i = 0; i < n; i++) begin
      m_if.RVALID = 1'b1;
      m_if.RDATA  = 32'hA000_0000 + i;
      m_if.RID    = id;
      m_if.RRESP  = 2'b00;
      m_if.RLAST  = (i == last_at);
      #1;
      chk({tag, "_rvalid"},   (idx == 0) ? s0_if.RVALID : s1_if.RVALID, 1);
      chk({tag, "_rvalid_o"}, (idx == 0) ? s1_if.RVALID : s0_if.RVALID, 0);
      chk({tag, "_rdata"},    (idx == 0) ? s0_if.RDATA  : s1_if.RDATA,  32'hA000_0000 + i);
      chk({tag, "_rid"},      (idx == 0) ? s0_if.RID    : s1_if.RID,    id);
      chk({tag, "_rready"},   m_if.RREADY, 1);
      chk({tag, "_arready_o"}, (idx == 0) ? s1_if.ARREADY : s0_if.ARREADY, 0);
      step();
    end
    m_if.RVALID = 1'b0;
    m_if.RLAST  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s0_if.AWID = '0; s0_if.AWADDR = '0; s0_if.AWLEN = '0; s0_if.AWSIZE = '0;
    s0_if.AWBURST = '0; s0_if.AWVALID = 1'b0; s0_if.WDATA = '0; s0_if.WSTRB = '0;
    s0_if.WLAST = 1'b0; s0_if.WVALID = 1'b0; s0_if.BREADY = 1'b0;
    s0_if.ARID = '0; s0_if.ARADDR = '0; s0_if.ARLEN = '0; s0_if.ARSIZE = 3'd2;
    s0_if.ARBURST = 2'b01; s0_if.ARVALID = 1'b0; s0_if.RREADY = 1'b1;
    s1_if.AWID = '0; s1_if.AWADDR = '0; s1_if.AWLEN = '0; s1_if.AWSIZE = '0;
    s1_if.AWBURST = '0; s1_if.AWVALID = 1'b0; s1_if.WDATA = '0; s1_if.WSTRB = '0;
    s1_if.WLAST = 1'b0; s1_if.WVALID = 1'b0; s1_if.BREADY = 1'b0;
    s1_if.ARID = '0; s1_if.ARADDR = '0; s1_if.ARLEN = '0; s1_if.ARSIZE = 3'd2;
    s1_if.ARBURST = 2'b01; s1_if.ARVALID = 1'b0; s1_if.RREADY = 1'b1;
    m_if.AWREADY = 1'b0; m_if.WREADY = 1'b0; m_if.BID = '0; m_if.BRESP = '0;
    m_if.BUSER = 1'b0; m_if.BVALID = 1'b0; m_if.ARREADY = 1'b1;
    m_if.RID = '0; m_if.RDATA = '0; m_if.RRESP = '0; m_if.RLAST = 1'b0; m_if.RVALID = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    m_if.RVALID = 1'b1;
    #1;
    chk("rst_grant",   grant, 2'b00);
    chk("rst_busy",    busy, 0);
    chk("rst_err",     err, 0);
    chk("rst_arvalid", m_if.ARVALID, 0);
    chk("rst_rready",  m_if.RREADY, 0);
    chk("rst_rvalid0", s0_if.RVALID, 0);
    chk("rst_rvalid1", s1_if.RVALID, 0);
    chk("rst_awvalid", m_if.AWVALID, 0);
    chk("rst_bvalid0", s0_if.BVALID, 0);
    m_if.RVALID = 1'b0;
    rst = 1'b0;
    step();

    // Single s0 request, ARLEN=3
    ar_req(0, 4'h5, 12'h123, 8'd3);
    #1;
    chk("t1_c0_arvalid", m_if.ARVALID, 0);
    chk("t1_c0_arready", s0_if.ARREADY, 0);
    chk("t1_c0_grant",   grant, 2'b00);
    step();
    chk("t1_c1_grant",   grant, 2'b01);
    chk("t1_c1_busy",    busy, 1);
    chk("t1_c1_arvalid", m_if.ARVALID, 1);
    chk("t1_c1_araddr",  m_if.ARADDR, 12'h123);
    chk("t1_c1_arid",    m_if.ARID, 4'h5);
    chk("t1_c1_arlen",   m_if.ARLEN, 8'd3);
    chk("t1_c1_arready0", s0_if.ARREADY, 1);
    chk("t1_c1_arready1", s1_if.ARREADY, 0);
    step();
    ar_drop(0);
    #1;
    chk("t1_data_arvalid", m_if.ARVALID, 0);
    chk("t1_data_busy",    busy, 1);
    run_beats(0, 4, 3, 4'h5, "t1");
    chk("t1_end_grant", grant, 2'b00);
    chk("t1_end_busy",  busy, 0);
    chk("t1_end_err",   err, 0);

    // Tie after reset: s0 first, then s1 on the repeat tie, then s0 alone
    reset_pulse();
    ar_req(0, 4'h1, 12'h010, 8'd0);
    ar_req(1, 4'h2, 12'h020, 8'd0);
    step();
    chk("t2_tie1_grant",  grant, 2'b01);
    chk("t2_tie1_araddr", m_if.ARADDR, 12'h010);
    chk("t2_tie1_arrdy1", s1_if.ARREADY, 0);
    step();
    ar_drop(0);
    run_beats(0, 1, 0, 4'h1, "t2a");
    ar_req(0, 4'h3, 12'h030, 8'd0);
    #1;
    chk("t2_idle_grant", grant, 2'b00);
    step();
    chk("t2_tie2_grant",  grant, 2'b10);
    chk("t2_tie2_araddr", m_if.ARADDR, 12'h020);
    chk("t2_tie2_arid",   m_if.ARID, 4'h2);
    chk("t2_tie2_arrdy0", s0_if.ARREADY, 0);
    step();
    ar_drop(1);
    run_beats(1, 1, 0, 4'h2, "t2b");
    step();
    chk("t2_third_grant",  grant, 2'b01);
    chk("t2_third_araddr", m_if.ARADDR, 12'h030);
    step();
    ar_drop(0);
    run_beats(0, 1, 0, 4'h3, "t2c");
    chk("t2_err", err, 0);

    // Early RLAST: ARLEN=1, RLAST on first beat
    ar_req(1, 4'h4, 12'h040, 8'd1);
    step();
    chk("t3_grant", grant, 2'b10);
    step();
    ar_drop(1);
    run_beats(1, 1, 0, 4'h4, "t3");
    chk("t3_err",   err, 1);
    chk("t3_busy",  busy, 0);
    chk("t3_grant_idle", grant, 2'b00);
    repeat (3) step();
    chk("t3_err_sticky", err, 1);

    // Missing RLAST on beat ARLEN: ARLEN=0, RLAST on second beat
    reset_pulse();
    chk("t3b_err_clear", err, 0);
    ar_req(0, 4'hB, 12'h0B0, 8'd0);
    step();
    step();
    ar_drop(0);
    run_beats(0, 2, 1, 4'hB, "t3b");
    chk("t3b_err",  err, 1);
    chk("t3b_busy", busy, 0);
    reset_pulse();
    chk("t3b_err_rst", err, 0);

    // s1 request while s0 in DATA with RREADY stalls
    ar_req(0, 4'h6, 12'h060, 8'd2);
    step();
    chk("t4_grant0", grant, 2'b01);
    step();
    ar_drop(0);
    ar_req(1, 4'h7, 12'h070, 8'd0);
    s0_if.RREADY = 1'b0;
    m_if.RVALID  = 1'b1;
    m_if.RLAST   = 1'b0;
    #1;
    chk("t4_stall_rready",  m_if.RREADY, 0);
    chk("t4_stall_rvalid0", s0_if.RVALID, 1);
    chk("t4_stall_rvalid1", s1_if.RVALID, 0);
    chk("t4_stall_arrdy1",  s1_if.ARREADY, 0);
    step();
    step();
    chk("t4_stall2_grant",   grant, 2'b01);
    chk("t4_stall2_arrdy1",  s1_if.ARREADY, 0);
    chk("t4_stall2_rvalid1", s1_if.RVALID, 0);
    s0_if.RREADY = 1'b1;
    run_beats(0, 3, 2, 4'h6, "t4");
    chk("t4_err",        err, 0);
    chk("t4_idle_grant", grant, 2'b00);
    chk("t4_idle_arrdy1", s1_if.ARREADY, 0);
    step();
    chk("t4_s1_grant",  grant, 2'b10);
    chk("t4_s1_arrdy1", s1_if.ARREADY, 1);
    chk("t4_s1_araddr", m_if.ARADDR, 12'h070);
    step();
    ar_drop(1);
    run_beats(1, 1, 0, 4'h7, "t4b");

    // Reset mid-DATA of an ARLEN=7 burst
    ar_req(0, 4'h8, 12'h080, 8'd7);
    step();
    step();
    ar_drop(0);
    run_beats(0, 2, 99, 4'h8, "t5");
    m_if.RVALID = 1'b1;
    #1;
    chk("t5_pre_rvalid0", s0_if.RVALID, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_grant",   grant, 2'b00);
    chk("t5_rst_busy",    busy, 0);
    chk("t5_rst_rvalid0", s0_if.RVALID, 0);
    chk("t5_rst_rready",  m_if.RREADY, 0);
    chk("t5_rst_err",     err, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("t5_post_rvalid0", s0_if.RVALID, 0);
    chk("t5_post_busy",    busy, 0);
    m_if.RVALID = 1'b0;
    ar_req(1, 4'h9, 12'h090, 8'd0);
    step();
    chk("t5_s1_grant",   grant, 2'b10);
    chk("t5_s1_araddr",  m_if.ARADDR, 12'h090);
    chk("t5_s1_arvalid", m_if.ARVALID, 1);
    step();
    ar_drop(1);
    run_beats(1, 1, 0, 4'h9, "t5b");
    chk("t5_end_busy", busy, 0);
    chk("t5_end_err",  err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi4_rd_arbiter.md
AXI4_RD_ARBITER -- requirements
Module: axi4_rd_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_BYTES, 4, data bus width in bytes, equal on all three ports.
- ADDR_WIDTH, 12, address width.
- ID_WIDTH, 4, ID width; ARID/RID pass through unmodified.
REQ-002 Ports, one per line: name, direction, width, meaning.
- ACLK, input, 1, sole clock; all state on rising edge.
- ARESET, input, 1, reset, asynchronous, active-high.
- s0, axi4_if.slave, -, upstream master 0 (read channels used).
- s1, axi4_if.slave, -, upstream master 1 (read channels used).
- m, axi4_if.master, -, shared downstream slave port.
- GRANT, output, 2, one-hot current owner; 00 when idle.
- BUSY, output, 1, high in ADDR or DATA state.
- ERR, output, 1, sticky RLAST/ARLEN mismatch flag.
REQ-003 The block shall have one clock; reset is asynchronous and active-high; interface ACLK/ARESETn members are unused by this block.

Function
REQ-004 FSM states IDLE, ADDR, DATA; one read burst outstanding at a time.
REQ-005 IDLE: m.ARVALID=0, s0/s1 ARREADY=0, RVALID=0; if any sX.ARVALID, register grant and go to ADDR next cycle.
REQ-006 Latency: sX.ARVALID rising in cycle N gives m.ARVALID=1 in cycle N+1 (one-cycle arbitration bubble).
REQ-007 Arbitration round-robin on register LAST (last-served index); single requester wins outright; both requesting -> winner is index != LAST.
REQ-008 ADDR: all m.AR* fields combinationally muxed from granted sX; m.ARVALID=sX.ARVALID; sX.ARREADY=m.ARREADY; non-granted ARREADY=0.
REQ-009 ADDR: on m.ARVALID&m.ARREADY capture ARLEN into LEN (8 bit), clear BEAT (9 bit), go to DATA.
REQ-010 DATA: m.R* fields routed to both sX; granted sX.RVALID=m.RVALID; non-granted RVALID=0; m.RREADY=granted sX.RREADY.
REQ-011 DATA: BEAT increments per R handshake; RLAST handshake -> IDLE next cycle, LAST<=granted index, GRANT<=00.
REQ-012 ERR set when R handshake has RLAST=1 and BEAT!=LEN, or RLAST=0 and BEAT==LEN; burst still ends only on RLAST.
REQ-013 ERR cleared only by reset.
REQ-014 Grant never changes outside IDLE; a request arriving in ADDR/DATA waits, ARREADY held 0.
REQ-015 Same-cycle IDLE return and new request: request sampled next IDLE cycle (no back-to-back grant without bubble).
REQ-016 Write channels unused: m.AW*/W*/BREADY driven 0; sX.AWREADY, WREADY, BVALID, BID, BRESP, BUSER driven 0.
REQ-017 m.ARVALID never deasserts in ADDR before handshake, as sX.ARVALID is stable per AXI.

Reset
REQ-018 ARESET high asynchronously forces IDLE, GRANT=00, BUSY=0, ERR=0, LAST=1 (master 0 wins first tie), LEN=0, BEAT=0, all VALID/READY outputs 0.
REQ-019 Reset mid-burst abandons burst; no further R beats forwarded; first post-reset grant follows REQ-007.

Verification
REQ-020 Bench shall cover:
- s0 ARVALID alone, ARLEN=3, 4 beats RLAST on 4th -> GRANT=01 cycle 1, m.ARVALID cycle 1, IDLE after beat 4, ERR=0.
- s0, s1 ARVALID same cycle after reset -> s0 served first, then s1; s1 served next on repeat tie.
- ARLEN=1, RLAST on beat 1 -> ERR=1, state IDLE, ERR stays 1 until reset.
- s1 request during s0 DATA with RREADY stalls -> s1.ARREADY=0 throughout, s1.RVALID=0, s1 granted after s0 RLAST plus one cycle.
- ARESET pulse mid-DATA, ARLEN=7 -> outputs zero immediately, BUSY=0, subsequent s1 request granted normally.
